// File: rtl/dac_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// dac_write_arbiter_if
// Handshake between the DAC write arbiter and one SPI_DAC8531 serializer.
//   DA_TR    trigger, driven by the arbiter, high while a write is launched
//   DA_DATA  16-bit word to serialize, driven by the arbiter
//   DA_OVER  serializer idle flag (1 = idle), driven by the serializer
// Modports: master = arbiter side, slave = serializer side.
// -----------------------------------------------------------------------------
interface dac_write_arbiter_if;
  logic        DA_TR;
  logic [15:0] DA_DATA;
  logic        DA_OVER;

  modport master (output DA_TR, output DA_DATA, input DA_OVER);
  modport slave  (input DA_TR, input DA_DATA, output DA_OVER);
endinterface

// File: rtl/dac_write_arbiter.sv
// -----------------------------------------------------------------------------
// dac_write_arbiter
// Shares one SPI_DAC8531 serializer between NUM_REQ writers. Round-robin
// arbitration, one write in flight, completion tracked through DA_OVER, a
// forced idle gap after every write and a timeout on a hung serializer.
// Ports:
//   CLOCK_10M  system clock, rising edge
//   RESET      synchronous, active-high reset
//   REQ        per-requester write request, held until GNT
//   REQ_DATA   requester k data in bits [16k+15:16k]
//   GNT        one-cycle pulse: requester k data captured
//   DONE       one-cycle pulse: requester k write finished
//   dac        serializer handshake (DA_TR, DA_DATA, DA_OVER)
//   BUSY       high in every state except IDLE
//   ERR        sticky timeout flag
//   LAST_DATA  last value successfully written
// -----------------------------------------------------------------------------
module dac_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int GAP_CYCLES = 100,
  parameter int TIMEOUT    = 1000,
  parameter int SKIP_SAME  = 1
) (
  input  logic                   CLOCK_10M,
  input  logic                   RESET,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [16*NUM_REQ-1:0]  REQ_DATA,
  output logic [NUM_REQ-1:0]     GNT,
  output logic [NUM_REQ-1:0]     DONE,
  dac_write_arbiter_if.master    dac,
  output logic                   BUSY,
  output logic                   ERR,
  output logic [15:0]            LAST_DATA
);

  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_TOP = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
  // LAUNCH also uses the counter (0..2), so it never gets narrower than that.
  localparam int CW      = $clog2(((CNT_TOP > 2) ? CNT_TOP : 2) + 1);

  localparam logic [CW-1:0] CNT_SAT  = '1;
  localparam logic [CW-1:0] TR_LAST  = CW'(2);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP
  } state_t;

  state_t               state, state_d;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        ptr;
  logic [NUM_REQ-1:0]   cur_sel;
  logic                 last_valid;
  logic                 skip_pend;

  logic                 win_valid;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        cand;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [15:0]          win_data;
  logic                 grant;
  logic                 skip;
  logic                 write_ok;
  logic                 timeout_hit;

  // With no gap configured a finished write goes straight back to IDLE.
  function automatic state_t post_write();
    if (GAP_CYCLES > 0) return GAP;
    return IDLE;
  endfunction

  // Round-robin winner: first set REQ bit searching upward from ptr+1.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    win_valid  = 1'b0;
    win_idx    = ptr;
    cand       = ptr;
    win_onehot = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_REQ);
      if (!win_valid && REQ[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
    win_onehot[win_idx] = 1'b1;
  end

  assign win_data = REQ_DATA[{win_idx, 4'b0000} +: 16];
  assign grant    = (state == IDLE) && win_valid && dac.DA_OVER;
  assign skip     = (SKIP_SAME != 0) && last_valid && (win_data == LAST_DATA);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process order.
  always_ff @(posedge CLOCK_10M) begin
    if (RESET) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:      if (grant) state_d = skip ? post_write() : LAUNCH;
      LAUNCH:    if (cnt == TR_LAST) state_d = WAIT_BUSY;
      WAIT_BUSY: if (!dac.DA_OVER) state_d = WAIT_DONE;
                 else if (timeout_hit) state_d = post_write();
      WAIT_DONE: if (write_ok || timeout_hit) state_d = post_write();
      GAP:       if (cnt == GAP_LAST) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output decode. The first LAUNCH cycle carries GNT, the next two carry TR.
  always_comb begin
    dac.DA_TR   = (state == LAUNCH) && (cnt != '0);
    BUSY        = (state != IDLE);
    write_ok    = (state == WAIT_DONE) && dac.DA_OVER;
    timeout_hit = (cnt == TO_LAST) &&
                  (((state == WAIT_BUSY) && dac.DA_OVER) ||
                   ((state == WAIT_DONE) && !dac.DA_OVER));
  end

  // Per-state cycle counter: cleared on every state change, saturating.
  always_ff @(posedge CLOCK_10M) begin
    if (RESET)                 cnt <= '0;
    else if (state_d != state) cnt <= '0;
    else if (cnt != CNT_SAT)   cnt <= cnt + 1'b1;
  end

  // Datapath and handshake registers.
  always_ff @(posedge CLOCK_10M) begin
    if (RESET) begin
      GNT         <= '0;
      DONE        <= '0;
      dac.DA_DATA <= '0;
      ERR         <= 1'b0;
      LAST_DATA   <= '0;
      last_valid  <= 1'b0;
      ptr         <= IW'(NUM_REQ - 1);
      cur_sel     <= '0;
      skip_pend   <= 1'b0;
    end else begin
      GNT       <= '0;
      DONE      <= '0;
      skip_pend <= 1'b0;
      if (grant) begin
        GNT         <= win_onehot;
        dac.DA_DATA <= win_data;
        ptr         <= win_idx;
        cur_sel     <= win_onehot;
        skip_pend   <= skip;
      end
      // A skipped write completes one cycle after its grant.
      if (skip_pend) DONE <= cur_sel;
      if (write_ok) begin
        DONE       <= cur_sel;
        LAST_DATA  <= dac.DA_DATA;
        last_valid <= 1'b1;
      end
      if (timeout_hit) ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dac_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dac_write_arbiter
// Bench for dac_write_arbiter with default parameters. A serializer model
// drives DA_OVER; expected grants (requester, data) are queued when requests
// are raised and popped by a monitor whenever GNT pulses.
// -----------------------------------------------------------------------------
module tb_dac_write_arbiter;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] data;
  } exp_t;

  typedef enum int {SER_NORMAL, SER_HUNG, SER_MANUAL} ser_mode_t;

  logic        CLOCK_10M = 1'b0;
  logic        RESET     = 1'b1;
  logic [2:0]  REQ       = '0;
  logic [47:0] REQ_DATA  = '0;
  logic [2:0]  GNT;
  logic [2:0]  DONE;
  logic        BUSY;
  logic        ERR;
  logic [15:0] LAST_DATA;

  dac_write_arbiter_if dac_bus();

  ser_mode_t ser_mode   = SER_NORMAL;
  logic      model_over = 1'b1;
  logic      man_over   = 1'b1;
  assign dac_bus.DA_OVER = (ser_mode == SER_MANUAL) ? man_over : model_over;

  dac_write_arbiter #(
    .NUM_REQ(3), .GAP_CYCLES(100), .TIMEOUT(1000), .SKIP_SAME(1)
  ) dut (
    .CLOCK_10M (CLOCK_10M),
    .RESET     (RESET),
    .REQ       (REQ),
    .REQ_DATA  (REQ_DATA),
    .GNT       (GNT),
    .DONE      (DONE),
    .dac       (dac_bus),
    .BUSY      (BUSY),
    .ERR       (ERR),
    .LAST_DATA (LAST_DATA)
  );

  always #50 CLOCK_10M = ~CLOCK_10M;

  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, gnt_total = 0, done_total = 0, tr_total = 0;
  int   over_falls = 0, over_rise_cyc = 0;
  logic [2:0] gnt_seen = '0;
  logic over_prev = 1'b1;
  exp_t exp_q[$];
  exp_t mon_e;

  always @(posedge CLOCK_10M) cyc++;

  // Serializer model: OVER drops one cycle after TR is seen, stays low 40 cycles.
  initial begin
    forever begin
      @(posedge CLOCK_10M);
      if (ser_mode == SER_NORMAL && dac_bus.DA_TR === 1'b1) begin
        #1 model_over = 1'b0;
        repeat (40) @(posedge CLOCK_10M);
        #1 model_over = 1'b1;
      end
    end
  end

  // Monitor: scoreboard pop on every grant plus event bookkeeping.
  always @(negedge CLOCK_10M) begin
    if (GNT !== 3'b000) begin
      gnt_total++;
      gnt_seen |= GNT;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL gnt_unexpected: GNT=%b while no grant expected", GNT);
      end else begin
        mon_e = exp_q.pop_front();
        if (GNT !== (3'b001 << mon_e.idx) || dac_bus.DA_DATA !== mon_e.data) begin
          n_fail++;
          $display("FAIL gnt_order: got GNT=%b DA_DATA=%h, expected GNT=%b DA_DATA=%h",
                   GNT, dac_bus.DA_DATA, 3'b001 << mon_e.idx, mon_e.data);
        end
      end
    end
    if (DONE !== 3'b000) begin
      done_total++;
      n_tests++;
      if (!$onehot(DONE)) begin
        n_fail++;
        $display("FAIL done_onehot: got DONE=%b, expected exactly one bit", DONE);
      end
    end
    if (dac_bus.DA_TR === 1'b1) tr_total++;
    if (over_prev === 1'b1 && dac_bus.DA_OVER === 1'b0) over_falls++;
    if (over_prev === 1'b0 && dac_bus.DA_OVER === 1'b1) over_rise_cyc = cyc;
    over_prev = dac_bus.DA_OVER;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge CLOCK_10M);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) tick();
    RESET = 1'b0;
    tick();
  endtask

  // Queue the expected grant, raise REQ[idx] and drop it in the grant cycle.
  task automatic grant_one(input int idx, input logic [15:0] data, output int lat);
    exp_q.push_back('{idx: 2'(idx), data: data});
    REQ_DATA[idx*16 +: 16] = data;
    REQ[idx] = 1'b1;
    lat = 0;
    while (GNT === 3'b000 && lat < 200) begin tick(); lat++; end
    REQ[idx] = 1'b0;
    if (GNT === 3'b000) begin
      n_tests++; n_fail++;
      $display("FAIL gnt_timeout: no GNT for requester %0d within 200 cycles", idx);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (DONE !== 3'b000) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: no DONE within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (BUSY === 1'b1 && n < budget) begin tick(); n++; end
    if (BUSY !== 1'b0) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: BUSY=%b after %0d cycles", BUSY, budget);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    REQ   = '0;
    repeat (3) tick();
    n_tests++;
    if ({GNT, DONE, dac_bus.DA_TR} !== 7'b0) begin
      n_fail++; $display("FAIL reset_handshake: GNT=%b DONE=%b DA_TR=%b, expected all 0", GNT, DONE, dac_bus.DA_TR);
    end
    n_tests++;
    if ({dac_bus.DA_DATA, LAST_DATA} !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: DA_DATA=%h LAST_DATA=%h, expected 0000", dac_bus.DA_DATA, LAST_DATA);
    end
    n_tests++;
    if ({BUSY, ERR} !== 2'b00) begin
      n_fail++; $display("FAIL reset_status: BUSY=%b ERR=%b, expected 0 0", BUSY, ERR);
    end
    RESET = 1'b0;
    tick();
    n_tests++;
    if ({BUSY, GNT} !== 4'b0) begin
      n_fail++; $display("FAIL reset_release: BUSY=%b GNT=%b, expected idle", BUSY, GNT);
    end
  endtask

  task automatic test_single();
    int lat, tr0, gap;
    bit ok;
    ser_mode = SER_NORMAL;
    tr0 = tr_total;
    grant_one(0, 16'h79E0, lat);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL single_latency: got %0d, expected 1", lat); end
    n_tests++;
    if (dac_bus.DA_TR !== 1'b0) begin n_fail++; $display("FAIL single_tr_gnt_cycle: got %b, expected 0", dac_bus.DA_TR); end
    tick();
    n_tests++;
    if (dac_bus.DA_TR !== 1'b1) begin n_fail++; $display("FAIL single_tr_first: got %b, expected 1", dac_bus.DA_TR); end
    tick();
    n_tests++;
    if (dac_bus.DA_TR !== 1'b1) begin n_fail++; $display("FAIL single_tr_second: got %b, expected 1", dac_bus.DA_TR); end
    tick();
    n_tests++;
    if (dac_bus.DA_TR !== 1'b0) begin n_fail++; $display("FAIL single_tr_end: got %b, expected 0", dac_bus.DA_TR); end
    wait_done(200, ok);
    if (ok) begin
      n_tests++;
      if (DONE !== 3'b001) begin n_fail++; $display("FAIL single_done: got %b, expected 001", DONE); end
      n_tests++;
      if (cyc !== over_rise_cyc + 1) begin
        n_fail++; $display("FAIL single_done_timing: DONE at cycle %0d, expected %0d", cyc, over_rise_cyc + 1);
      end
      n_tests++;
      if (LAST_DATA !== 16'h79E0) begin n_fail++; $display("FAIL single_last_data: got %h, expected 79e0", LAST_DATA); end
      n_tests++;
      if (tr_total - tr0 !== 2) begin n_fail++; $display("FAIL single_tr_len: got %0d TR cycles, expected 2", tr_total - tr0); end
    end
    wait_idle(400, gap);
    n_tests++;
    if (gap !== 100) begin n_fail++; $display("FAIL single_gap: got %0d busy cycles after DONE, expected 100", gap); end
  endtask

  task automatic test_round_robin();
    int g0, d0, n;
    do_reset();
    g0 = gnt_total;
    d0 = done_total;
    exp_q.push_back('{idx: 2'd0, data: 16'h1111});
    exp_q.push_back('{idx: 2'd1, data: 16'h2222});
    exp_q.push_back('{idx: 2'd2, data: 16'h3333});
    exp_q.push_back('{idx: 2'd0, data: 16'h1111});
    REQ_DATA = {16'h3333, 16'h2222, 16'h1111};
    REQ = 3'b111;
    n = 0;
    while (gnt_total < g0 + 4 && n < 1500) begin tick(); n++; end
    REQ = 3'b000;
    n_tests++;
    if (gnt_total - g0 !== 4) begin n_fail++; $display("FAIL rr_grants: got %0d grants, expected 4", gnt_total - g0); end
    wait_idle(400, n);
    n_tests++;
    if (done_total - d0 !== 4) begin n_fail++; $display("FAIL rr_dones: got %0d, expected 4", done_total - d0); end
    n_tests++;
    if (LAST_DATA !== 16'h1111) begin n_fail++; $display("FAIL rr_last_data: got %h, expected 1111", LAST_DATA); end
  endtask

  task automatic test_skip_same();
    int lat, n, tr0, of0;
    bit ok;
    grant_one(1, 16'h8000, lat);
    wait_done(200, ok);
    wait_idle(400, n);
    n_tests++;
    if (LAST_DATA !== 16'h8000) begin n_fail++; $display("FAIL skip_first_write: got %h, expected 8000", LAST_DATA); end
    tr0 = tr_total;
    of0 = over_falls;
    grant_one(1, 16'h8000, lat);
    tick();
    n_tests++;
    if (DONE !== 3'b010) begin n_fail++; $display("FAIL skip_done: got %b one cycle after GNT, expected 010", DONE); end
    wait_idle(400, n);
    n_tests++;
    if (tr_total !== tr0 || over_falls !== of0) begin
      n_fail++; $display("FAIL skip_no_transfer: %0d TR cycles, %0d OVER falls, expected 0 and 0", tr_total - tr0, over_falls - of0);
    end
  endtask

  task automatic test_hung();
    int lat, n, d0;
    bit ok;
    ser_mode = SER_HUNG;
    d0 = done_total;
    grant_one(2, 16'h4242, lat);
    n = 0;
    while (ERR !== 1'b1 && n < 1200) begin tick(); n++; end
    n_tests++;
    if (ERR !== 1'b1 || n < 995 || n > 1010) begin
      n_fail++; $display("FAIL hung_timeout: ERR=%b after %0d cycles, expected 1 after about 1003", ERR, n);
    end
    n_tests++;
    if (done_total !== d0 || LAST_DATA !== 16'h8000) begin
      n_fail++; $display("FAIL hung_side_effects: %0d DONE, LAST_DATA=%h, expected 0 and 8000", done_total - d0, LAST_DATA);
    end
    wait_idle(300, n);
    ser_mode = SER_NORMAL;
    grant_one(0, 16'h0123, lat);
    wait_done(200, ok);
    if (ok) begin
      n_tests++;
      if (DONE !== 3'b001 || LAST_DATA !== 16'h0123 || ERR !== 1'b1) begin
        n_fail++; $display("FAIL hung_recover: DONE=%b LAST_DATA=%h ERR=%b, expected 001 0123 1", DONE, LAST_DATA, ERR);
      end
    end
    wait_idle(400, n);
  endtask

  task automatic test_reset_mid_transfer();
    int lat, n, d0, g0;
    grant_one(1, 16'h5555, lat);
    d0 = done_total;
    n = 0;
    while (dac_bus.DA_OVER !== 1'b0 && n < 50) begin tick(); n++; end
    repeat (5) tick();
    RESET = 1'b1;
    tick();
    n_tests++;
    if ({dac_bus.DA_TR, BUSY, ERR} !== 3'b000 || LAST_DATA !== 16'h0000) begin
      n_fail++; $display("FAIL midreset_state: DA_TR=%b BUSY=%b ERR=%b LAST_DATA=%h, expected 0 0 0 0000",
                         dac_bus.DA_TR, BUSY, ERR, LAST_DATA);
    end
    RESET = 1'b0;
    n = 0;
    while (dac_bus.DA_OVER !== 1'b1 && n < 100) begin tick(); n++; end
    repeat (3) tick();
    n_tests++;
    if (done_total !== d0) begin n_fail++; $display("FAIL midreset_no_done: got %0d DONE pulses, expected 0", done_total - d0); end
    g0 = gnt_total;
    exp_q.push_back('{idx: 2'd0, data: 16'hA0A0});
    exp_q.push_back('{idx: 2'd1, data: 16'hB0B0});
    REQ_DATA[15:0]  = 16'hA0A0;
    REQ_DATA[31:16] = 16'hB0B0;
    REQ = 3'b011;
    n = 0;
    while (gnt_total == g0 && n < 50) begin tick(); n++; end
    REQ[0] = 1'b0;
    n = 0;
    while (gnt_total < g0 + 2 && n < 400) begin tick(); n++; end
    REQ[1] = 1'b0;
    n_tests++;
    if (gnt_total - g0 !== 2) begin n_fail++; $display("FAIL midreset_grants: got %0d, expected 2", gnt_total - g0); end
    wait_idle(400, n);
  endtask

  task automatic test_withdraw_stall();
    int lat, n, g0;
    bit ok;
    gnt_seen = '0;
    grant_one(0, 16'h0F0F, lat);
    repeat (5) tick();
    REQ_DATA[47:32] = 16'h2020;
    REQ[2] = 1'b1;
    repeat (10) tick();
    n_tests++;
    if (BUSY !== 1'b1) begin n_fail++; $display("FAIL withdraw_busy: BUSY=%b while REQ[2] held, expected 1", BUSY); end
    REQ[2] = 1'b0;
    wait_idle(400, n);
    repeat (5) tick();
    n_tests++;
    if (gnt_seen[2] !== 1'b0) begin n_fail++; $display("FAIL withdraw_no_gnt: GNT[2] seen=%b, expected 0", gnt_seen[2]); end
    ser_mode = SER_MANUAL;
    man_over = 1'b0;
    g0 = gnt_total;
    exp_q.push_back('{idx: 2'd1, data: 16'h1234});
    REQ_DATA[31:16] = 16'h1234;
    REQ[1] = 1'b1;
    repeat (20) tick();
    n_tests++;
    if (gnt_total !== g0 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL stall_no_gnt: %0d grants, BUSY=%b with DA_OVER=0, expected 0 and 0", gnt_total - g0, BUSY);
    end
    man_over = 1'b1;
    n = 0;
    while (GNT === 3'b000 && n < 10) begin tick(); n++; end
    REQ[1] = 1'b0;
    ser_mode = SER_NORMAL;
    n_tests++;
    if (n !== 1) begin n_fail++; $display("FAIL stall_release_latency: got %0d, expected 1", n); end
    wait_done(200, ok);
    if (ok) begin
      n_tests++;
      if (DONE !== 3'b010) begin n_fail++; $display("FAIL stall_done: got %b, expected 010", DONE); end
    end
    wait_idle(400, n);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_skip_same();
    test_hung();
    test_reset_mid_transfer();
    test_withdraw_stall();
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d expected grants never seen, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_write_arbiter.md
# dac_write_arbiter

Shares the single SPI_DAC8531 serializer (TR/DATA/OVER handshake) between NUM_REQ independent writers, for example the frequency-calibration loop, a host override and a power-up preset loader. The block performs round-robin arbitration, launches one DAC write at a time and tracks completion through OVER. It enforces a minimum settling gap between writes and detects a hung serializer with a timeout. It sits between the requesters and the serializer instance, one per DAC.

## Interface
- NUM_REQ, 3: number of requesters (2..8)
- GAP_CYCLES, 100: idle cycles forced after each completed or aborted write (0 allowed)
- TIMEOUT, 1000: maximum cycles spent in each of WAIT_BUSY and WAIT_DONE
- SKIP_SAME, 1: when 1, a request whose data equals the last written value completes without a DAC transfer

- CLOCK_10M  in  1  system clock; all logic is on the rising edge
- RESET  in  1  synchronous, active-high reset
- REQ  in  NUM_REQ  per-requester write request, level-held until GNT
- REQ_DATA  in  16*NUM_REQ  requester k data in bits [16k+15:16k], stable while REQ[k] is high
- GNT  out  NUM_REQ  one-cycle pulse: requester k data captured
- DONE  out  NUM_REQ  one-cycle pulse: requester k write finished successfully
- DA_TR  out  1  serializer trigger
- DA_DATA  out  16  serializer data word
- DA_OVER  in  1  serializer idle flag (1 = idle)
- BUSY  out  1  high in every state except IDLE
- ERR  out  1  sticky timeout flag, cleared only by RESET
- LAST_DATA  out  16  last value successfully written

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if any REQ bit is set and DA_OVER=1, select the winner k using round-robin priority, searching from (ptr+1) mod NUM_REQ upward. The next edge does the following: DA_DATA<=REQ_DATA[k], GNT[k]<=1, ptr<=k.
  - If SKIP_SAME=1, last_valid=1 and the data equals LAST_DATA: go to GAP and pulse DONE[k] on the following cycle. No TR is issued.
  - Otherwise go to LAUNCH.
- LAUNCH: DA_TR=1 for exactly 2 cycles, then go to WAIT_BUSY with the timeout counter cleared.
- WAIT_BUSY: wait for DA_OVER=0, then go to WAIT_DONE with the counter cleared.
- WAIT_DONE: wait for DA_OVER=1, then DONE[k]<=1, LAST_DATA<=DA_DATA, last_valid<=1, go to GAP.
- Timeout: if the counter reaches TIMEOUT in WAIT_BUSY or WAIT_DONE, then ERR<=1, go to GAP. No DONE is pulsed and LAST_DATA is unchanged.
- GAP: count GAP_CYCLES cycles, then go to IDLE. If GAP_CYCLES=0, go directly to IDLE.
- REQ bits are sampled only in IDLE. Dropping REQ before GNT withdraws the request with no side effects.
- Requests arriving while BUSY=1 wait; none are lost while held.
- At most one GNT bit and one DONE bit are high in any cycle.
- Counters are sized as $clog2(max(GAP_CYCLES,TIMEOUT)+1) bits and saturate (no wrap).

## Timing
- Reset values: GNT=0, DONE=0, DA_TR=0, DA_DATA=0, BUSY=0, ERR=0, LAST_DATA=0, last_valid=0, ptr=NUM_REQ-1 (requester 0 wins first), state=IDLE.
- RESET asserted mid-transfer returns the block to these values on the next edge. DA_TR drops immediately and no DONE is issued for the aborted write.
- Latency from REQ to GNT: 1 edge when IDLE and DA_OVER=1.
- DA_TR rises in the cycle after GNT is high.
- DONE is high in the cycle after DA_OVER is sampled high in WAIT_DONE.
- Skip path: GNT in cycle n, DONE in cycle n+1.
- If DA_OVER=0 while in IDLE, the block stalls in IDLE without granting.
- If REQ[k] is still high in the cycle GNT[k] is pulsed, it is treated as a new request at the next IDLE.

## Test plan
- Single write: REQ[0]=1, data 0x79E0. Serializer model drops OVER 1 cycle after TR and holds it low 40 cycles. Required: 1 GNT[0], 2-cycle DA_TR, DA_DATA=0x79E0, DONE[0] one cycle after OVER rises, LAST_DATA=0x79E0, then GAP of 100 cycles.
- Round-robin: REQ=3'b111 held continuously with data 0x1111/0x2222/0x3333. Required: grant order 0,1,2,0 and DA_DATA following that order.
- Skip same value: write 0x8000 from requester 1, then request 0x8000 again. Required: the second request produces GNT then DONE one cycle later, with no DA_TR and no change in DA_OVER.
- Hung serializer: OVER held at 1 after TR. Required: ERR=1 after TIMEOUT=1000 cycles in WAIT_BUSY, no DONE, LAST_DATA unchanged, BUSY low after GAP, and the next request is still served.
- Reset mid-transfer: assert RESET during WAIT_DONE. Required: DA_TR=0, BUSY=0, ERR=0, LAST_DATA=0 next cycle, no DONE pulse, and requester 0 wins first afterwards.
- Withdrawn request and busy stall: drop REQ[2] while another write is BUSY, before its grant. Required: GNT[2] never asserts. Also hold DA_OVER=0 in IDLE. Required: no grant until DA_OVER=1.
